lab2_pio_seq: RTL and testbench
===============================

LAB2_PIO_SEQ -- requirements
Module: lab2_pio_seq

Interface
REQ-001 Parameter DIV_W, default 26: width of the tick divider.
REQ-002 Parameter MAX_CNT, default 9: count wrap value; legal range 1..15.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle pulse; begins sequencing.
REQ-006 Port stop, input, 1: one-cycle pulse; ends sequencing.
REQ-007 Port up_down, input, 1: 1 = count up, 0 = count down; sampled at each step.
REQ-008 Port div_value, input, DIV_W: clock cycles per step; sampled when start is accepted.
REQ-009 Ports pio_address (output, 2), pio_chipselect (output, 1), pio_write_n (output, 1), pio_writedata (output, 32): Avalon-MM master drive to the 4-bit PIO slave.
REQ-010 Port pio_readdata, input, 32: PIO read data, combinational from the slave.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port count, output, 4: last value written to the PIO.
REQ-013 Port mismatch, output, 1: sticky readback-error flag.

Function
REQ-014 FSM states SHALL be IDLE, WAIT_TICK, WRITE, READBACK, CHECK.
REQ-015 IDLE: start SHALL latch div_value (0 treated as 1), clear the divider, clear mismatch, and go to WRITE.
REQ-016 WRITE: the block SHALL hold pio_chipselect=1, pio_write_n=0, pio_address=0 and pio_writedata={28'b0,count} for exactly one cycle, then go to READBACK.
REQ-017 READBACK: the block SHALL hold pio_chipselect=1, pio_write_n=1 and pio_address=0 for one cycle, register pio_readdata[3:0] at the end of that cycle, then go to CHECK.
REQ-018 CHECK: if the captured value differs from count, mismatch SHALL set and stay set. The FSM SHALL then go to WAIT_TICK.
REQ-019 WAIT_TICK: the divider SHALL count from 0. When it reaches the latched divisor minus 1, count SHALL step and the FSM SHALL go to WRITE.
REQ-020 Step rules: up from MAX_CNT wraps to 0; down from 0 wraps to MAX_CNT; arithmetic is 4-bit unsigned.
REQ-021 Outside WRITE and READBACK, pio_chipselect SHALL be 0, pio_write_n 1, pio_address 0, pio_writedata 0.
REQ-022 stop SHALL be honoured only in WAIT_TICK: the FSM goes to IDLE and count holds its value. A stop seen in WRITE, READBACK or CHECK SHALL be latched and applied at the next WAIT_TICK cycle.
REQ-023 start outside IDLE SHALL be ignored. If start and stop occur in the same cycle, stop wins and start is dropped.
REQ-024 If the step tick and stop coincide in WAIT_TICK, stop wins: no step and no write.
REQ-025 The first write after start SHALL carry the current count, without a step. The first step SHALL occur one divisor period after CHECK.
REQ-026 Step-to-step period SHALL be divisor+3 cycles: divisor cycles in WAIT_TICK plus WRITE, READBACK and CHECK.

Reset
REQ-027 When reset is asserted, the state SHALL be IDLE; count, mismatch, busy, divider, latched stop and all pio_* outputs SHALL be 0, except pio_write_n which SHALL be 1.
REQ-028 Reset asserted mid-transaction SHALL abort it immediately, with no further bus activity. The PIO contents are not restored.

Structure
REQ-029 A shared package lab2_pkg SHALL hold the state enumeration, PIO_DATA_ADDR=0 and PIO_W=4.
REQ-030 The divider SHALL be one sub-module, lab2_tick_div, with ports clk, reset, clr, load value and tick output.
REQ-031 The block SHALL have no combinational path from start, stop or pio_readdata to any output.

Verification
REQ-032 Bench SHALL pair the DUT with the 4-bit PIO model, with readdata combinational from the data register.
REQ-033 Scenario: div_value=4, up_down=1, start -> PIO writes 0, 1, 2, with the second write 4+3 cycles after the first; mismatch=0.
REQ-034 Scenario: count=9, up -> next write 0. count=0, down -> next write 9.
REQ-035 Scenario: stop pulsed during WRITE -> READBACK and CHECK complete, then IDLE on the following cycle; count holds; busy=0.
REQ-036 Scenario: PIO model forced to return 4'hF on read -> mismatch=1 after CHECK; it stays 1 through later good steps and clears only on start or reset.
REQ-037 Scenario: reset asserted during READBACK -> chipselect=0 and count=0 asynchronously; with start and stop pulsed together in IDLE -> remains IDLE.
REQ-038 Scenario: div_value=0 -> behaves as divisor 1, with a step period of 4 cycles.

Source files
------------

// File: rtl/lab2_pkg.sv
// Shared types and constants for the PIO sequencer.
package lab2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitTick,
    StWrite,
    StReadback,
    StCheck
  } state_t;

  localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;
  localparam int unsigned PIO_W         = 4;

  // Next count value with wrap between 0 and max_v in either direction.
  function automatic logic [PIO_W-1:0] step_count(input logic [PIO_W-1:0] cur,
                                                  input logic             up,
                                                  input logic [PIO_W-1:0] max_v);
    logic [PIO_W-1:0] nxt;
    if (up) begin
      nxt = (cur == max_v) ? '0 : cur + 1'b1;
    end else begin
      nxt = (cur == '0) ? max_v : cur - 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lab2_tick_div.sv
// Step divider: counts from 0 while enabled (clr low) and pulses tick on divisor-1.
module lab2_tick_div #(
  parameter int unsigned DIV_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  // Divisor latch; a zero request behaves as divide-by-one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (load) begin
      div_q <= (value == '0) ? DIV_W'(1) : value;
    end
  end

  // Free-running cycle counter, held at zero whenever clr is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

  // Registered-only terms, so tick has no path from any module input.
  always_comb begin
    tick = (div_q != '0) && (cnt_q == div_q - DIV_W'(1));
  end

endmodule

// File: rtl/lab2_pio_seq.sv
// Counter sequencer that writes each count to a 4-bit Avalon PIO and reads it back.
module lab2_pio_seq
  import lab2_pkg::*;
#(
  parameter int unsigned DIV_W   = 26,
  parameter int unsigned MAX_CNT = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             up_down,
  input  logic [DIV_W-1:0] div_value,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  output logic             busy,
  output logic [3:0]       count,
  output logic             mismatch
);

  localparam logic [PIO_W-1:0] MaxCnt = PIO_W'(MAX_CNT);

  state_t           state_q, state_d;
  logic [PIO_W-1:0] count_q, count_d;
  logic [PIO_W-1:0] rd_q, rd_d;
  logic             mismatch_q, mismatch_d;
  logic             stop_pend_q, stop_pend_d;
  logic             div_load, div_clr, tick;
  logic             unused_rd;

  assign unused_rd = ^pio_readdata[31:PIO_W];

  lab2_tick_div #(
    .DIV_W(DIV_W)
  ) u_tick_div (
    .clk  (clk),
    .reset(reset),
    .clr  (div_clr),
    .load (div_load),
    .value(div_value),
    .tick (tick)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      rd_q        <= '0;
      mismatch_q  <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_q        <= rd_d;
      mismatch_q  <= mismatch_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Next-state logic; stop only takes effect in WaitTick, earlier stops are held pending.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_d        = rd_q;
    mismatch_d  = mismatch_q;
    stop_pend_d = stop_pend_q;
    div_load    = 1'b0;
    div_clr     = (state_q != StWaitTick);
    unique case (state_q)
      StIdle: begin
        // stop beats a simultaneous start
        if (start && !stop) begin
          div_load   = 1'b1;
          mismatch_d = 1'b0;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        if (stop) stop_pend_d = 1'b1;
        state_d = StReadback;
      end
      StReadback: begin
        if (stop) stop_pend_d = 1'b1;
        rd_d    = pio_readdata[PIO_W-1:0];
        state_d = StCheck;
      end
      StCheck: begin
        if (stop) stop_pend_d = 1'b1;
        if (rd_q != count_q) mismatch_d = 1'b1;
        state_d = StWaitTick;
      end
      StWaitTick: begin
        if (stop || stop_pend_q) begin
          stop_pend_d = 1'b0;
          state_d     = StIdle;
        end else if (tick) begin
          count_d = step_count(count_q, up_down, MaxCnt);
          state_d = StWrite;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    pio_address    = PIO_DATA_ADDR;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    unique case (state_q)
      StWrite: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_writedata  = {{(32-PIO_W){1'b0}}, count_q};
      end
      StReadback: pio_chipselect = 1'b1;
      default: ;
    endcase
    busy     = (state_q != StIdle);
    count    = count_q;
    mismatch = mismatch_q;
  end

endmodule

// File: tb/tb_lab2_pio_seq.sv
// Self-checking bench: DUT paired with a 4-bit PIO model, checked against a write-schedule model.
module tb_lab2_pio_seq;

  localparam int unsigned DIV_W   = 26;
  localparam int unsigned MAX_CNT = 9;

  logic             clk = 1'b0;
  logic             reset, start, stop, up_down;
  logic [DIV_W-1:0] div_value;
  logic [1:0]       pio_address;
  logic             pio_chipselect, pio_write_n;
  logic [31:0]      pio_writedata, pio_readdata;
  logic             busy, mismatch;
  logic [3:0]       count;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  logic [3:0]  pio_reg = 4'h0;
  logic        force_bad = 1'b0;
  logic [31:0] wr_data[$];
  int unsigned wr_edge[$];
  logic [3:0]  cur = 4'h0;

  lab2_pio_seq #(
    .DIV_W  (DIV_W),
    .MAX_CNT(MAX_CNT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .up_down       (up_down),
    .div_value     (div_value),
    .pio_address   (pio_address),
    .pio_chipselect(pio_chipselect),
    .pio_write_n   (pio_write_n),
    .pio_writedata (pio_writedata),
    .pio_readdata  (pio_readdata),
    .busy          (busy),
    .count         (count),
    .mismatch      (mismatch)
  );

  always #5 clk = ~clk;

  // PIO slave model plus write log; cyc equals the edge number between edges.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pio_chipselect && !pio_write_n && pio_address == 2'd0) begin
      pio_reg <= pio_writedata[3:0];
      wr_data.push_back(pio_writedata);
      wr_edge.push_back(cyc + 1);
    end
  end

  assign pio_readdata = force_bad ? 32'h0000_000F : {28'h0, pio_reg};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_step(input logic [3:0] v, input bit up);
    int n;
    n = up ? int'(v) + 1 : int'(v) - 1;
    if (n > int'(MAX_CNT)) n = 0;
    if (n < 0) n = int'(MAX_CNT);
    return 4'(n);
  endfunction

  task automatic chk_bus_idle();
    chk("idle_cs", {31'h0, pio_chipselect}, 32'h0);
    chk("idle_wn", {31'h0, pio_write_n}, 32'h1);
    chk("idle_addr", {30'h0, pio_address}, 32'h0);
    chk("idle_wdata", pio_writedata, 32'h0);
  endtask

  // One start..stop run. Writes land at t0 + j*p; a stop seen at edge s ends after write
  // i = (s-t0)/p, taking effect at s, or at t_i+3 if it arrived during write/readback/check.
  task automatic run_trial(input int unsigned d_in, input bit ud, input int unsigned off,
                           input bit bad);
    int unsigned d, p, k, t0, s, i, ti, e_idle, base, nwr;
    logic [3:0] v;
    d  = (d_in == 0) ? 1 : d_in;
    p  = d + 3;
    @(negedge clk);
    div_value = DIV_W'(d_in);
    up_down   = ud;
    force_bad = bad;
    start     = 1'b1;
    k      = cyc + 1;
    t0     = k + 1;
    s      = t0 + off;
    i      = off / p;
    ti     = t0 + i * p;
    e_idle = ((s - ti) <= 2) ? ti + 3 : s;
    base   = wr_data.size();
    @(negedge clk);
    start = 1'b0;
    chk("mismatch_clr_on_start", {31'h0, mismatch}, 32'h0);
    while (cyc < e_idle + 2) begin
      stop = (cyc == s - 1);
      if (bad && cyc == t0 + 1) begin
        chk("mismatch_before_check", {31'h0, mismatch}, 32'h0);
        force_bad = 1'b0;
      end
      if (bad && cyc == t0 + 2) chk("mismatch_after_check", {31'h0, mismatch}, 32'h1);
      if (cyc == e_idle - 1) chk("busy_before_idle", {31'h0, busy}, 32'h1);
      if (cyc == e_idle) chk("busy_at_idle", {31'h0, busy}, 32'h0);
      @(negedge clk);
    end
    stop = 1'b0;
    nwr = wr_data.size() - base;
    chk("write_count", nwr, i + 1);
    v = cur;
    for (int j = 0; j <= int'(i); j++) begin
      if (j > 0) v = ref_step(v, ud);
      if (j < int'(nwr)) begin
        chk("write_data", wr_data[base+j], {28'h0, v});
        chk("write_edge", wr_edge[base+j], t0 + j * p);
      end
    end
    chk("count_hold", {28'h0, count}, {28'h0, v});
    chk("mismatch_end", {31'h0, mismatch}, {31'h0, bad});
    chk_bus_idle();
    cur = v;
  endtask

  // Reset during readback, then a simultaneous start/stop that must be dropped.
  task automatic reset_trial();
    int unsigned base;
    base = wr_data.size();
    @(negedge clk);
    div_value = DIV_W'(4);
    up_down   = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_cs", {31'h0, pio_chipselect}, 32'h0);
    chk("rst_count", {28'h0, count}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_wn", {31'h0, pio_write_n}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    cur = 4'h0;
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (6) @(negedge clk);
    chk("startstop_busy", {31'h0, busy}, 32'h0);
    chk("rst_writes", wr_data.size() - base, 1);
    chk_bus_idle();
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    up_down   = 1'b1;
    div_value = '0;
    repeat (2) @(negedge clk);
    chk("reset_count", {28'h0, count}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_mismatch", {31'h0, mismatch}, 32'h0);
    chk_bus_idle();
    reset = 1'b0;
    @(negedge clk);

    run_trial(4, 1'b1, 75, 1'b0);   // 0..9 then wrap to 0
    run_trial(0, 1'b0, 9, 1'b0);    // divisor 0 as 1; 0 -> 9 -> 8
    run_trial(4, 1'b1, 0, 1'b0);    // stop during the first write
    run_trial(3, 1'b1, 20, 1'b1);   // bad readback, sticky mismatch
    run_trial(2, 1'b0, 8, 1'b0);    // start clears mismatch
    reset_trial();
    for (int n = 0; n < 20; n++) begin
      int unsigned d;
      d = $urandom_range(0, 6);
      run_trial(d, 1'($urandom_range(0, 1)), $urandom_range(0, 4 * (((d == 0) ? 1 : d) + 3)),
                ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
